// File: rtl/stream_adapter_if.sv
// Pixel-stream bundle between the image source, stream_adapter and the rotation core.
// slave is the adapter side; master is the side that drives the stream and accepts the head.
interface stream_adapter_if #(
  parameter int unsigned CH    = 3,
  parameter int unsigned CW    = 8,
  parameter int unsigned DEPTH = 16
) ();
  localparam int unsigned AW = $clog2(DEPTH);

  logic [1:0]       mode_in;
  logic             valid_in;
  logic             start_in;
  logic             jump_in;
  logic [CH*CW-1:0] data_in;
  logic             ready_out;
  logic             valid_out;
  logic             ready_in;
  logic             start_out;
  logic             jump_out;
  logic [CH*CW-1:0] data_out;
  logic [AW:0]      level_out;
  logic             len_err_out;
  logic             ovf_out;

  modport slave (
    input  mode_in, valid_in, start_in, jump_in, data_in, ready_in,
    output ready_out, valid_out, start_out, jump_out, data_out, level_out, len_err_out, ovf_out
  );

  modport master (
    output mode_in, valid_in, start_in, jump_in, data_in, ready_in,
    input  ready_out, valid_out, start_out, jump_out, data_out, level_out, len_err_out, ovf_out
  );
endinterface

// File: rtl/stream_adapter.sv
// Frame-gated pixel adapter: per-frame channel transform, line-length check and an output
// FIFO that absorbs downstream backpressure and reports drops.
module stream_adapter #(
  parameter int unsigned CH     = 3,
  parameter int unsigned CW     = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned LINE_W = 1024
) (
  input logic              clk_in,
  input logic              rst_n_in,
  stream_adapter_if.slave  s_io
);
  localparam int unsigned AW     = $clog2(DEPTH);
  localparam int unsigned DataW  = CH * CW;
  localparam int unsigned EntryW = DataW + 2;
  localparam int unsigned ColW   = $clog2(LINE_W) + 1;

  localparam logic [AW:0]     DepthC = (AW + 1)'(DEPTH);
  localparam logic [AW:0]     CntOne = (AW + 1)'(1);
  localparam logic [AW-1:0]   PtrOne = AW'(1);
  localparam logic [ColW-1:0] ColOne = ColW'(1);
  localparam logic [ColW-1:0] LineWC = ColW'(LINE_W);

  logic [1:0]        act_mode_q, act_mode_d;
  logic              in_frame_q, in_frame_d;
  logic [ColW-1:0]   col_q, col_d;
  logic [AW-1:0]     rptr_q, rptr_d;
  logic [AW-1:0]     wptr_q, wptr_d;
  logic [AW:0]       count_q, count_d;
  logic              len_err_q, len_err_d;
  logic              ovf_q, ovf_d;
  logic [EntryW-1:0] mem_q [DEPTH];

  logic              start_acc;
  logic [1:0]        eff_mode;
  logic              eligible;
  logic              full;
  logic              empty;
  logic              pop;
  logic              push;
  logic              drop;
  logic [ColW-1:0]   col_base;
  logic [ColW-1:0]   col_inc;
  logic [DataW-1:0]  xform;
  logic [EntryW-1:0] head;

  // A start beat carries its own mode; every other beat uses the mode latched at frame start.
  assign start_acc = s_io.valid_in && s_io.start_in;
  assign eff_mode  = s_io.start_in ? s_io.mode_in : act_mode_q;
  assign eligible  = s_io.valid_in && (s_io.start_in ? (s_io.mode_in != 2'b00) : in_frame_q);

  assign full  = (count_q == DepthC);
  assign empty = (count_q == '0);
  assign pop   = !empty && s_io.ready_in;
  // When full, a same-cycle pop frees the slot so the beat is still taken.
  assign push  = eligible && (!full || pop);
  assign drop  = eligible && full && !pop;

  assign col_base = s_io.start_in ? '0 : col_q;
  assign col_inc  = col_base + ColOne;

  always_comb begin
    xform = s_io.data_in;
    case (eff_mode)
      2'b10: begin
        for (int unsigned k = 0; k < CH; k++) begin
          xform[k*CW +: CW] = s_io.data_in[(CH-1-k)*CW +: CW];
        end
      end
      2'b11: begin
        for (int unsigned k = 0; k < CH; k++) begin
          xform[k*CW +: CW] = s_io.data_in[CW-1:0];
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    act_mode_d = act_mode_q;
    in_frame_d = in_frame_q;
    col_d      = col_q;
    len_err_d  = len_err_q;
    ovf_d      = ovf_q;
    rptr_d     = rptr_q;
    wptr_d     = wptr_q;
    count_d    = count_q;

    if (start_acc) begin
      act_mode_d = s_io.mode_in;
      in_frame_d = (s_io.mode_in != 2'b00);
    end

    // Geometry tracking advances on every eligible beat, dropped or not.
    if (eligible) begin
      if (s_io.jump_in) begin
        if (col_inc != LineWC) begin
          len_err_d = 1'b1;
        end
        col_d = '0;
      end else begin
        col_d = col_inc;
      end
    end

    if (drop) begin
      ovf_d = 1'b1;
    end

    if (push) begin
      wptr_d = wptr_q + PtrOne;
    end
    if (pop) begin
      rptr_d = rptr_q + PtrOne;
    end
    if (push && !pop) begin
      count_d = count_q + CntOne;
    end else if (pop && !push) begin
      count_d = count_q - CntOne;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      act_mode_q <= 2'b00;
      in_frame_q <= 1'b0;
      col_q      <= '0;
      len_err_q  <= 1'b0;
      ovf_q      <= 1'b0;
      rptr_q     <= '0;
      wptr_q     <= '0;
      count_q    <= '0;
    end else begin
      act_mode_q <= act_mode_d;
      in_frame_q <= in_frame_d;
      col_q      <= col_d;
      len_err_q  <= len_err_d;
      ovf_q      <= ovf_d;
      rptr_q     <= rptr_d;
      wptr_q     <= wptr_d;
      count_q    <= count_d;
    end
  end

  // Storage needs no reset: outputs are masked while empty.
  always_ff @(posedge clk_in) begin
    if (push) begin
      mem_q[wptr_q] <= {s_io.start_in, s_io.jump_in, xform};
    end
  end

  assign head = mem_q[rptr_q];

  always_comb begin
    s_io.valid_out   = !empty;
    s_io.ready_out   = !full;
    s_io.level_out   = count_q;
    s_io.len_err_out = len_err_q;
    s_io.ovf_out     = ovf_q;
    s_io.start_out   = 1'b0;
    s_io.jump_out    = 1'b0;
    s_io.data_out    = '0;
    if (!empty) begin
      {s_io.start_out, s_io.jump_out, s_io.data_out} = head;
    end
  end
endmodule

// File: tb/tb_stream_adapter.sv
// Scoreboard bench for stream_adapter: stimulus queues expected head beats, a negedge
// monitor pops and compares them whenever the DUT hands a beat downstream.
module tb_stream_adapter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  stream_adapter_if #(.CH(3), .CW(8), .DEPTH(16)) sif ();

  stream_adapter #(.CH(3), .CW(8), .DEPTH(16), .LINE_W(4)) dut (
    .clk_in  (clk),
    .rst_n_in(rst_n),
    .s_io    (sif)
  );

  typedef struct packed {
    logic        s;
    logic        j;
    logic [23:0] d;
  } beat_t;

  beat_t exp_q[$];
  beat_t mon_e;
  int    n_checks = 0;
  int    n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one beat for one edge; e is the hand-computed transformed pixel.
  task automatic send(input logic s, input logic j, input logic [1:0] m, input logic [23:0] d,
                      input logic [23:0] e, input bit expect_out);
    sif.valid_in = 1'b1;
    sif.start_in = s;
    sif.jump_in  = j;
    sif.mode_in  = m;
    sif.data_in  = d;
    if (expect_out) exp_q.push_back(beat_t'{s, j, e});
    @(posedge clk);
    #1;
    sif.valid_in = 1'b0;
    sif.start_in = 1'b0;
    sif.jump_in  = 1'b0;
  endtask

  task automatic wait_drain(input int max);
    int k = 0;
    while (sif.level_out != 0 && k < max) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("drain_done", 32'(sif.level_out), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"},   32'(sif.valid_out),   32'd0);
    chk({tag, "_ready"},   32'(sif.ready_out),   32'd1);
    chk({tag, "_level"},   32'(sif.level_out),   32'd0);
    chk({tag, "_markers"}, 32'({sif.start_out, sif.jump_out}), 32'd0);
    chk({tag, "_data"},    32'(sif.data_out),    32'd0);
    chk({tag, "_len_err"}, 32'(sif.len_err_out), 32'd0);
    chk({tag, "_ovf"},     32'(sif.ovf_out),     32'd0);
  endtask

  always @(negedge clk) begin
    if (rst_n && sif.valid_out && sif.ready_in) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_beat: got %0h expected none", sif.data_out);
      end else begin
        mon_e = exp_q.pop_front();
        chk("out_beat", 32'({sif.start_out, sif.jump_out, sif.data_out}), 32'(mon_e));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    sif.valid_in = 1'b0;
    sif.start_in = 1'b0;
    sif.jump_in  = 1'b0;
    sif.mode_in  = 2'b00;
    sif.data_in  = '0;
    sif.ready_in = 1'b0;
    idle(2);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    idle(1);

    // Pass mode: each beat must be the head one cycle after it is presented.
    sif.ready_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      logic [23:0] d;
      logic        s, j;
      d = 24'h010203 + 24'(i);
      s = (i == 0);
      j = (i == 3) || (i == 7);
      send(s, j, 2'b01, d, d, 1'b1);
      chk("pass_head", 32'({sif.valid_out, sif.start_out, sif.jump_out, sif.data_out}),
          32'({1'b1, s, j, d}));
      chk("pass_level", 32'(sif.level_out), 32'd1);
    end
    idle(2);
    chk("pass_len_err", 32'(sif.len_err_out), 32'd0);
    chk("pass_idle_level", 32'(sif.level_out), 32'd0);

    // Reverse frame then mono frame.
    send(1'b1, 1'b0, 2'b10, 24'hAABBCC, 24'hCCBBAA, 1'b1);
    send(1'b0, 1'b0, 2'b10, 24'h112233, 24'h332211, 1'b1);
    send(1'b0, 1'b0, 2'b10, 24'h445566, 24'h665544, 1'b1);
    send(1'b0, 1'b1, 2'b10, 24'h778899, 24'h998877, 1'b1);
    send(1'b1, 1'b0, 2'b11, 24'hAABBCC, 24'hCCCCCC, 1'b1);
    send(1'b0, 1'b0, 2'b11, 24'h123456, 24'h565656, 1'b1);
    send(1'b0, 1'b0, 2'b11, 24'hABCDEF, 24'hEFEFEF, 1'b1);
    send(1'b0, 1'b1, 2'b11, 24'h0F1E2D, 24'h2D2D2D, 1'b1);

    // Mode changes mid-frame are ignored.
    send(1'b1, 1'b0, 2'b01, 24'h102030, 24'h102030, 1'b1);
    send(1'b0, 1'b0, 2'b10, 24'h405060, 24'h405060, 1'b1);
    send(1'b0, 1'b0, 2'b11, 24'h708090, 24'h708090, 1'b1);
    send(1'b0, 1'b1, 2'b10, 24'hA0B0C0, 24'hA0B0C0, 1'b1);
    idle(2);
    chk("midframe_len_err", 32'(sif.len_err_out), 32'd0);

    // Off frame: nothing written, short line inside it is not checked.
    send(1'b1, 1'b0, 2'b00, 24'h111111, 24'h0, 1'b0);
    send(1'b0, 1'b0, 2'b01, 24'h222222, 24'h0, 1'b0);
    send(1'b0, 1'b1, 2'b01, 24'h333333, 24'h0, 1'b0);
    chk("off_valid", 32'(sif.valid_out), 32'd0);
    chk("off_level", 32'(sif.level_out), 32'd0);
    chk("off_len_err", 32'(sif.len_err_out), 32'd0);

    // Fill to full, then push and pop together while full.
    sif.ready_in = 1'b0;
    for (int i = 0; i < 16; i++)
      send(i == 0, (i % 4) == 3, 2'b01, 24'h200000 + 24'(i), 24'h200000 + 24'(i), 1'b1);
    chk("full_level", 32'(sif.level_out), 32'd16);
    chk("full_ready", 32'(sif.ready_out), 32'd0);
    chk("full_ovf", 32'(sif.ovf_out), 32'd0);
    sif.ready_in = 1'b1;
    for (int i = 16; i < 21; i++) begin
      send(1'b0, (i % 4) == 3, 2'b01, 24'h200000 + 24'(i), 24'h200000 + 24'(i), 1'b1);
      chk("pushpop_level", 32'(sif.level_out), 32'd16);
      chk("pushpop_ovf", 32'(sif.ovf_out), 32'd0);
    end
    wait_drain(40);
    chk("pushpop_queue", 32'(exp_q.size()), 32'd0);

    // Overflow: 18 beats into a stalled FIFO, the last two are dropped.
    sif.ready_in = 1'b0;
    for (int i = 0; i < 18; i++) begin
      send(i == 0, (i % 4) == 3, 2'b01, 24'h300000 + 24'(i), 24'h300000 + 24'(i), i < 16);
      if (i == 15) chk("ovf_before", 32'(sif.ovf_out), 32'd0);
    end
    chk("ovf_level", 32'(sif.level_out), 32'd16);
    chk("ovf_ready", 32'(sif.ready_out), 32'd0);
    chk("ovf_flag", 32'(sif.ovf_out), 32'd1);
    sif.ready_in = 1'b1;
    wait_drain(40);
    chk("ovf_queue", 32'(exp_q.size()), 32'd0);

    // Short line: jump on column 2 of a 4-pixel line.
    chk("len_before", 32'(sif.len_err_out), 32'd0);
    send(1'b1, 1'b0, 2'b01, 24'h400000, 24'h400000, 1'b1);
    send(1'b0, 1'b0, 2'b01, 24'h400001, 24'h400001, 1'b1);
    chk("len_mid", 32'(sif.len_err_out), 32'd0);
    send(1'b0, 1'b1, 2'b01, 24'h400002, 24'h400002, 1'b1);
    chk("len_err", 32'(sif.len_err_out), 32'd1);
    idle(2);

    // Reset with 5 beats buffered discards them.
    sif.ready_in = 1'b0;
    for (int i = 0; i < 5; i++)
      send(1'b0, 1'b0, 2'b01, 24'h500000 + 24'(i), 24'h500000 + 24'(i), 1'b1);
    chk("prereset_level", 32'(sif.level_out), 32'd5);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    chk_reset_outputs("midreset");
    exp_q.delete();

    // Reset also clears the frame state: a bare non-start beat is discarded.
    sif.ready_in = 1'b1;
    send(1'b0, 1'b0, 2'b01, 24'h600000, 24'h0, 1'b0);
    idle(1);
    chk("postreset_valid", 32'(sif.valid_out), 32'd0);
    chk("final_queue", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
